// File: rtl/lfsr_encrypt_engine.sv
// LFSR stream encryptor: reads a message and three config bytes from the shared
// 128-byte memory and writes a 64-byte space-padded ciphertext frame to 64..127.
module lfsr_encrypt_engine #(
  parameter bit         PARITY   = 1'b0,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [6:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam int unsigned AW  = 7;
  localparam int unsigned DW  = 8;
  localparam int unsigned LW  = 7;
  localparam int unsigned KW  = 6;
  localparam int unsigned PLW = 5;

  localparam logic [AW-1:0] ADDR_LEN  = 7'd61;
  localparam logic [AW-1:0] ADDR_TAP  = 7'd62;
  localparam logic [AW-1:0] ADDR_SEED = 7'd63;
  localparam logic [AW-1:0] ADDR_OUT  = 7'd64;
  localparam logic [AW-1:0] MSG_LAST  = 7'd60;
  localparam logic [DW-1:0] PL_MIN    = 8'd10;
  localparam logic [DW-1:0] PL_MAX    = 8'd26;
  localparam logic [KW-1:0] K_LAST    = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_LEN, S_CFG_TAP, S_CFG_SEED, S_RD, S_WR, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             phase, phase_nxt;
  logic             req_q;
  logic [KW-1:0]    k, k_nxt;
  logic [PLW-1:0]   pl;
  logic [LW-1:0]    taps;
  logic [LW-1:0]    lfsr;
  logic [LW-1:0]    lfsr_step;
  logic [AW-1:0]    addr_nxt;
  logic             wr_en_nxt;
  logic             ack_nxt;
  logic [DW-1:0]    plain;
  logic [DW-1:0]    cipher;

  // Message index of output byte kk for a frame with len leading pad bytes
  function automatic logic [AW-1:0] msg_offset(input logic [KW-1:0] kk, input logic [PLW-1:0] len);
    return AW'(kk) - AW'(len);
  endfunction

  // Output byte kk falls in the leading or trailing padding
  function automatic logic msg_pad(input logic [KW-1:0] kk, input logic [PLW-1:0] len);
    return (AW'(kk) < AW'(len)) || (msg_offset(kk, len) > MSG_LAST);
  endfunction

  assign lfsr_step = {lfsr[LW-2:0], ^(lfsr & taps)};

  // State register
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state logic; each config state spends an address cycle and a capture cycle
  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    case (state)
      S_IDLE:     if (req_q && !req) state_nxt = S_CFG_LEN;
      S_CFG_LEN:  if (!phase) phase_nxt = 1'b1; else state_nxt = S_CFG_TAP;
      S_CFG_TAP:  if (!phase) phase_nxt = 1'b1; else state_nxt = S_CFG_SEED;
      S_CFG_SEED: if (!phase) phase_nxt = 1'b1; else state_nxt = S_RD;
      S_RD:       state_nxt = S_WR;
      S_WR:       state_nxt = (k == K_LAST) ? S_DONE : S_RD;
      S_DONE:     if (req) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus the write data path
  always_comb begin
    k_nxt     = k;
    addr_nxt  = '0;
    wr_en_nxt = 1'b0;
    ack_nxt   = 1'b0;
    if (state == S_IDLE) k_nxt = '0;
    else if (state == S_WR) k_nxt = k + KW'(1);
    case (state_nxt)
      S_CFG_LEN:  addr_nxt = ADDR_LEN;
      S_CFG_TAP:  addr_nxt = ADDR_TAP;
      S_CFG_SEED: addr_nxt = ADDR_SEED;
      S_RD:       addr_nxt = msg_pad(k_nxt, pl) ? '0 : msg_offset(k_nxt, pl);
      S_WR: begin
        addr_nxt  = ADDR_OUT + AW'(k_nxt);
        wr_en_nxt = 1'b1;
      end
      S_DONE:     ack_nxt = 1'b1;
      default:    addr_nxt = '0;
    endcase

    plain  = msg_pad(k, pl) ? PAD_CHAR : mem_rd_data;
    cipher = DW'(plain - PAD_CHAR) ^ {1'b0, lfsr};
    if (PARITY) cipher[DW-1] = ^cipher[DW-2:0];
    mem_wr_data = (state == S_WR) ? cipher : '0;
  end

  // Config capture, LFSR, byte counter and registered outputs
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      req_q     <= 1'b0;
      k         <= '0;
      pl        <= PLW'(PL_MIN);
      taps      <= '0;
      lfsr      <= LW'(1);
      ack       <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
    end else begin
      req_q     <= (state == S_IDLE) ? req : 1'b0;
      k         <= k_nxt;
      ack       <= ack_nxt;
      mem_addr  <= addr_nxt;
      mem_wr_en <= wr_en_nxt;
      if (phase) begin
        case (state)
          S_CFG_LEN: begin
            if (mem_rd_data < PL_MIN)      pl <= PLW'(PL_MIN);
            else if (mem_rd_data > PL_MAX) pl <= PLW'(PL_MAX);
            else                           pl <= PLW'(mem_rd_data);
          end
          S_CFG_TAP:  taps <= mem_rd_data[LW-1:0];
          S_CFG_SEED: lfsr <= (mem_rd_data[LW-1:0] == '0) ? LW'(1) : mem_rd_data[LW-1:0];
          default: ;
        endcase
      end
      if (state == S_WR) lfsr <= lfsr_step;
    end
  end

endmodule

// File: doc/lfsr_encrypt_engine.md
# lfsr_encrypt_engine

Hardware encryption stage that sits directly upstream of the message-decryption program. It reads a raw ASCII message and three configuration bytes from the shared 128-byte data memory. It builds a 64-byte space-padded frame, subtracts 0x20 from each byte, XORs it with a 7-bit maximal-length LFSR sequence, and writes the 64 ciphertext bytes to addresses 64..127, where the decrypter consumes them.

## Interface
Parameters:
- PARITY, default 0: when 1, ciphertext bit 7 is replaced by the even parity (XOR) of bits 6:0.
- PAD_CHAR, default 8'h20: padding character and subtraction offset.

Ports:
- clk  input  1  rising-edge system clock.
- init  input  1  reset; asynchronous, active-high.
- req  input  1  start request; a run launches on a high-to-low transition.
- ack  output  1  run complete; held high until req is next sampled high.
- mem_addr  output  7  data-memory address.
- mem_rd_data  input  8  read data; synchronous memory, valid one cycle after mem_addr.
- mem_wr_en  output  1  write strobe; memory writes on the rising edge while high.
- mem_wr_data  output  8  write data.

## Operation
- Memory map:
  - 0..60: plaintext message; bytes beyond the message are already 0x20.
  - 61: pre_length.
  - 62: tap pattern (7 bits).
  - 63: LFSR seed (7 bits).
  - 64..127: ciphertext output.
- States: IDLE → CFG_LEN → CFG_TAP → CFG_SEED → RD → WR → (RD, or DONE after byte 63) → DONE.
- IDLE: waits for req sampled 1 then 0 on consecutive edges.
- CFG_* states: each takes 2 cycles (drive address, then capture).
  - pre_length is clamped to the range 10..26.
  - The tap pattern uses bits 6:0 and is applied as-is.
  - A seed of 0 is forced to 7'h01.
- Per output byte k = 0..63:
  - Plaintext p = PAD_CHAR when k < pre_length or k − pre_length > 60; otherwise p = mem[k − pre_length].
  - RD drives the read address. Padding bytes still spend the RD cycle, with no read data used, so timing is constant.
  - WR drives mem_wr_en=1, mem_addr = 64+k, mem_wr_data = (p − PAD_CHAR) ^ {1'b0, lfsr}. The subtraction is 8-bit mod 256.
  - If PARITY=1, bit 7 = ^data[6:0].
  - LFSR advances after each WR: lfsr ← {lfsr[5:0], ^(lfsr & taps)}.
- Byte 0 uses the seed itself.
- DONE: ack=1, mem_wr_en=0. Returns to IDLE, with ack cleared, on the first edge where req=1.
- req toggling during a run is ignored. Only a fresh 1→0 transition seen in IDLE launches a run.
- Reset mid-run: all state is discarded immediately, with no further writes. Memory already written is left as-is.

## Timing
- Reset values:
  - ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - State IDLE, lfsr=7'h01, pre_length=10, taps=0.
- Cycle 0 is the edge at which IDLE samples req low after high.
- Configuration occupies cycles 0..5; byte k RD and WR fall at cycles 6+2k and 7+2k.
- The last write (address 127) is at cycle 133. ack is high from cycle 134.
- Total latency from start edge to ack is exactly 134 cycles, independent of data.
- mem_wr_en is never high outside WR states. There is exactly one write per address 64..127 per run.

## Test plan
- Message "@@@@", taps 0x48, seed 0x01, pre_length 10:
  - mem[64..73] = 01 02 04 08 11 22 44 09 13 26.
  - mem[74] = 0x6C.
  - ack rises 134 cycles after the req fall.
- Seed 0x00 with the scenario-1 settings → output identical to seed 0x01.
- pre_length 5 → behaves as 10; pre_length 30 → behaves as 26 (first message byte lands at address 90).
- PARITY=1, scenario-1 settings → mem[67] = 0x88 (0x08 with parity bit set), mem[64] = 0x81.
- Assert init at cycle 40 of a run → mem_wr_en drops the same cycle, ack=0, no writes after cycle 40. A new req 1→0 then produces a full correct 64-byte run.
- Toggle req high for 3 cycles mid-run → the run completes unchanged. ack rises at 134 and clears on the next req=1 sample.
